// File: rtl/mult_div_seq_if.sv
// Handshake and operand/result bundle for the sequential multiply/divide unit.
interface mult_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, is_signed, a, b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, is_signed, a, b,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/mult_div_seq.sv
// Sequential multiply/divide unit for the HI/LO path.
// Multiply: shift-add on operand magnitudes, one multiplier bit per cycle, LSB first.
// Divide: restoring division on magnitudes, one quotient bit per cycle, MSB first.
// Signs are applied in the FIX cycle; divide-by-zero skips CALC entirely.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mult_div_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   ONE_2W   = (2*WIDTH)'(1);
  localparam logic [WIDTH-1:0]     ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement negate of a single-width value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + ONE_W;
  endfunction

  // Two's-complement negate of a double-width value.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + ONE_2W;
  endfunction

  // Magnitude of an operand; raw value in unsigned mode. MIN maps onto
  // itself, which read as unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic sgn);
    return (sgn && x[WIDTH-1]) ? neg_w(x) : x;
  endfunction

  state_t             state;
  logic [CW-1:0]      count;
  logic               op_l;
  logic               sign_q;
  logic               sign_r;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               div_zero;

  logic [WIDTH:0]     add_src;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.hi       = hi;
  assign bus.lo       = lo;
  assign bus.div_zero = div_zero;

  // One iteration step of each algorithm plus the final sign correction.
  always_comb begin
    add_src   = {(WIDTH+1){1'b0}};
    if (acc[0]) begin
      add_src = {1'b0, mag_a};
    end else begin
      add_src = {(WIDTH+1){1'b0}};
    end
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + add_src;
    div_shift = {rem, quo[WIDTH-1]};
    div_trial = div_shift - {1'b0, mag_b};
    prod_fix  = sign_q ? neg_2w(acc) : acc;
    quo_fix   = sign_q ? neg_w(quo) : quo;
    rem_fix   = sign_r ? neg_w(rem) : rem;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= {CW{1'b0}};
      op_l     <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      mag_a    <= ZERO_W;
      mag_b    <= ZERO_W;
      acc      <= {(2*WIDTH){1'b0}};
      rem      <= ZERO_W;
      quo      <= ZERO_W;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= ZERO_W;
      lo       <= ZERO_W;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_l     <= bus.op;
            sign_q   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            sign_r   <= bus.is_signed & bus.a[WIDTH-1];
            mag_a    <= magnitude(bus.a, bus.is_signed);
            mag_b    <= magnitude(bus.b, bus.is_signed);
            acc      <= {ZERO_W, magnitude(bus.b, bus.is_signed)};
            rem      <= ZERO_W;
            quo      <= magnitude(bus.a, bus.is_signed);
            count    <= {CW{1'b0}};
            div_zero <= 1'b0;
            busy     <= 1'b1;
            if (bus.op && (bus.b == ZERO_W)) begin
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (op_l) begin
            // A negative trial means the divisor did not fit: restore.
            if (div_trial[WIDTH]) begin
              rem <= div_shift[WIDTH-1:0];
            end else begin
              rem <= div_trial[WIDTH-1:0];
            end
            quo <= {quo[WIDTH-2:0], ~div_trial[WIDTH]};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (count == CNT_LAST) begin
            count <= {CW{1'b0}};
            state <= FIX;
          end else begin
            count <= count + CNT_ONE;
          end
        end
        FIX: begin
          if (op_l) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          // Arriving from FIX, done is already up. Arriving straight from
          // IDLE (divide by zero), spend one extra cycle raising it.
          if (!done) begin
            done     <= 1'b1;
            div_zero <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed self-checking bench for mult_div_seq (WIDTH = 32).
module tb_mult_div_seq;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mult_div_seq_if #(.WIDTH(32)) bus ();

  mult_div_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from a negedge and follow it to done. If glitch > 0,
  // a conflicting start is pulsed at that cycle count while the unit is busy.
  task automatic run_op(input logic o, input logic s,
                        input logic [31:0] va, input logic [31:0] vb,
                        input int glitch, input int exp_lat,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input string tag);
    int   n;
    logic busy_ok;
    n       = 0;
    busy_ok = 1'b1;
    bus.start     = 1'b1;
    bus.op        = o;
    bus.is_signed = s;
    bus.a         = va;
    bus.b         = vb;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = ~o;
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'h00000000;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == glitch) begin
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) break;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " busy"}, {63'd0, busy_ok}, 64'd1);
    check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, ehi});
    check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, elo});
    check({tag, " div_zero"}, {63'd0, bus.div_zero}, {63'd0, edz});
    @(negedge clk);
    check({tag, " done pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
  endtask

  initial begin
    logic quiet;
    tests = 0;
    fails = 0;
    bus.start     = 1'b0;
    bus.op        = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset hi", {32'd0, bus.hi}, 64'd0);
    check("reset lo", {32'd0, bus.lo}, 64'd0);
    check("reset div_zero", {63'd0, bus.div_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 1'b0, 32'h0000FFFF, 32'hFFFFFFFF, 0, 34, 32'h0000FFFE, 32'hFFFF0001, 1'b0, "umul");
    run_op(1'b0, 1'b1, 32'h0000FFFF, 32'hFFFFFFFF, 0, 34, 32'hFFFFFFFF, 32'hFFFF0001, 1'b0, "smul");
    run_op(1'b0, 1'b1, 32'h80000000, 32'h80000000, 0, 34, 32'h40000000, 32'h00000000, 1'b0, "smul min");
    run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 0, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "sdiv");
    run_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 0, 34, 32'h00000001, 32'h7FFFFFFC, 1'b0, "udiv");
    run_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 34, 32'h00000000, 32'h80000000, 1'b0, "sdiv min");
    run_op(1'b1, 1'b1, 32'h00001234, 32'h00000000, 0, 2,  32'h00000000, 32'h80000000, 1'b1, "div zero");
    run_op(1'b0, 1'b0, 32'd3, 32'd5, 0, 34, 32'h00000000, 32'h0000000F, 1'b0, "after dz");
    run_op(1'b0, 1'b0, 32'd6, 32'd7, 5, 34, 32'h00000000, 32'h0000002A, 1'b0, "start ignored");

    // Abort in flight: reset sampled at the edge of CALC iteration 10.
    bus.start     = 1'b1;
    bus.op        = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = 32'd9;
    bus.b         = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", {63'd0, bus.busy}, 64'd0);
    check("abort done", {63'd0, bus.done}, 64'd0);
    check("abort hi", {32'd0, bus.hi}, 64'd0);
    check("abort lo", {32'd0, bus.lo}, 64'd0);
    check("abort div_zero", {63'd0, bus.div_zero}, 64'd0);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    check("abort no done", {63'd0, quiet}, 64'd1);
    run_op(1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 0, 34, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, "post abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
